// File: rtl/rom_arbiter_if.sv
// Request/grant and ROM/response bundle for rom_arbiter.
// The arbiter takes the slave side; requesters plus the ROM model take the master side.
interface rom_arbiter_if #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned ID_WIDTH   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*LEN_WIDTH-1:0]  req_len;
  logic [N_REQ-1:0]            gnt;
  logic                        busy;
  logic [ADDR_WIDTH-1:0]       rom_addr;
  logic [DATA_WIDTH-1:0]       rom_data;
  logic                        rsp_valid;
  logic [ID_WIDTH-1:0]         rsp_id;
  logic                        rsp_last;
  logic [DATA_WIDTH-1:0]       rsp_data;
  logic                        rsp_err;

  modport slave (
    input  req, req_addr, req_len, rom_data,
    output gnt, busy, rom_addr, rsp_valid, rsp_id, rsp_last, rsp_data, rsp_err
  );

  modport master (
    output req, req_addr, req_len, rom_data,
    input  gnt, busy, rom_addr, rsp_valid, rsp_id, rsp_last, rsp_data, rsp_err
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter + burst sequencer sharing one registered-read ROM among N_REQ requesters.
// Define ROM_ARB_RANGE_CHECK_EN to flag beats at addresses >= MEM_SIZE (rsp_err=1, rsp_data=0).
module rom_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned MEM_SIZE   = 2**ADDR_WIDTH,
  parameter int unsigned ID_WIDTH   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  rom_arbiter_if.slave bus
);

`ifdef ROM_ARB_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_q;
  logic [ID_WIDTH-1:0]   win;
  logic [ID_WIDTH-1:0]   cand;
  logic                  found;
  logic                  grant;
  logic [N_REQ-1:0]      gnt_d;
  logic [ID_WIDTH-1:0]   owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic                  rsp_valid_q;
  logic                  rsp_last_q;
  logic                  rsp_err_q;
  logic [ID_WIDTH-1:0]   rsp_id_q;

  // First requester at or after the RR pointer, scanning with wrap-around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ID_WIDTH'((32'(rr_q) + i) % N_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // rst_n gates the grant so no gnt pulse leaks out while reset is held.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    gnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (found && rst_n) begin
          grant      = 1'b1;
          gnt_d[win] = 1'b1;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (remain_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      remain_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= (state_q == BURST);
      if (grant) begin
        addr_q   <= bus.req_addr[32'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        remain_q <= bus.req_len[32'(win)*LEN_WIDTH +: LEN_WIDTH];
        owner_q  <= win;
        rr_q     <= ID_WIDTH'((32'(win) + 32'd1) % N_REQ);
      end
      if (state_q == BURST) begin
        rsp_id_q   <= owner_q;
        rsp_last_q <= (remain_q == '0);
        rsp_err_q  <= RANGE_CHECK && (32'(addr_q) >= MEM_SIZE);
        // After the last beat the address register holds its final value.
        if (remain_q != '0) begin
          addr_q   <= addr_q + 1'b1;
          remain_q <= remain_q - 1'b1;
        end
      end else begin
        rsp_last_q <= 1'b0;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  assign bus.gnt       = gnt_d;
  assign bus.busy      = (state_q == BURST) || grant;
  assign bus.rom_addr  = addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_err_q ? '0 : bus.rom_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter: directed scenarios plus random traffic scored against a
// transaction-level model (RR pointer, expected issue/response beat queues).
module tb_rom_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int MS = 200;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;

  rom_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IW)) bus ();

  rom_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MEM_SIZE(MS), .ID_WIDTH(IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // ROM: registered read, one-cycle latency.
  logic [DW-1:0] rom_mem [2**AW];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.rom_data <= rom_mem[bus.rom_addr];
  end

  typedef struct {
    int unsigned   cyc;
    logic [AW-1:0] addr;
    int unsigned   id;
    bit            last;
  } beat_t;

  beat_t iss_q[$];
  beat_t rsp_q[$];
  int unsigned rr_m = 0;
  int unsigned free_at = 0;

  // Reference model: predicts grants, busy, issued addresses and response beats.
  always @(negedge clk) begin
    logic [N-1:0]  exp_gnt;
    beat_t         bt;
    int unsigned   w, len, a;
    bit            ok;
    bit            exp_e;
    logic [DW-1:0] exp_d;
    if (!rst_n) begin
      iss_q.delete();
      rsp_q.delete();
      rr_m = 0;
      free_at = 0;
    end else begin
      exp_gnt = '0;
      if (cyc >= free_at && bus.req != '0) begin
        ok = 0;
        w = 0;
        for (int k = 0; k < N; k++)
          if (!ok && bus.req[(rr_m + k) % N]) begin
            ok = 1;
            w = (rr_m + k) % N;
          end
        exp_gnt[w] = 1'b1;
        len = bus.req_len[w*LW +: LW];
        a   = bus.req_addr[w*AW +: AW];
        for (int unsigned b = 0; b <= len; b++) begin
          bt.cyc  = cyc + 1 + b;
          bt.addr = AW'((a + b) % (2**AW));
          bt.id   = w;
          bt.last = (b == len);
          iss_q.push_back(bt);
        end
        rr_m = (w + 1) % N;
        free_at = cyc + len + 2;
      end
      total++;
      if (bus.gnt !== exp_gnt) begin
        bad++;
        $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, exp_gnt);
      end
      total++;
      if (bus.busy !== (cyc < free_at)) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, (cyc < free_at));
      end
      if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
        bt = iss_q.pop_front();
        total++;
        if (bus.rom_addr !== bt.addr) begin
          bad++;
          $display("FAIL rom_addr cyc=%0d got=%h exp=%h", cyc, bus.rom_addr, bt.addr);
        end
        bt.cyc = cyc + 1;
        rsp_q.push_back(bt);
      end
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
        bt = rsp_q.pop_front();
`ifdef ROM_ARB_RANGE_CHECK_EN
        exp_e = (int'(bt.addr) >= MS);
`else
        exp_e = 1'b0;
`endif
        exp_d = exp_e ? '0 : rom_mem[bt.addr];
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IW'(bt.id) || bus.rsp_last !== bt.last ||
            bus.rsp_err !== exp_e || bus.rsp_data !== exp_d) begin
          bad++;
          $display("FAIL rsp cyc=%0d got v=%b id=%0d last=%b err=%b data=%h exp v=1 id=%0d last=%b err=%b data=%h",
                   cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_last, bus.rsp_err, bus.rsp_data,
                   bt.id, bt.last, exp_e, exp_d);
        end
      end else begin
        total++;
        if (bus.rsp_valid !== 1'b0) begin
          bad++;
          $display("FAIL rsp_valid_idle cyc=%0d got=%b exp=0", cyc, bus.rsp_valid);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int l);
    bus.req[i] = 1'b1;
    bus.req_addr[i*AW +: AW] = AW'(a);
    bus.req_len[i*LW +: LW]  = LW'(l);
  endtask

  task automatic wait_grant(output int idx, output bit ok);
    ok = 0;
    idx = -1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (bus.gnt[i]) begin
          idx = i;
          ok = 1;
        end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '1;
    #2;
    total++; if (bus.gnt !== '0)        begin bad++; $display("FAIL reset_gnt got=%b exp=0", bus.gnt); end
    total++; if (bus.busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.rom_addr !== '0)   begin bad++; $display("FAIL reset_rom_addr got=%h exp=0", bus.rom_addr); end
    tick();
    bus.req = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int idx, g;
    bit ok;
    set_req(0, 'h10, 3);
    wait_grant(idx, ok);
    g = int'(cyc);
    total++; if (!ok || idx != 0) begin bad++; $display("FAIL single_gnt got=%0d exp=0", idx); end
    tick();
    bus.req = '0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      total++;
      if (int'(cyc) != g + j) begin bad++; $display("FAIL single_timing got=%0d exp=%0d", cyc, g + j); end
      if (j <= 4) begin
        total++;
        if (bus.rom_addr !== AW'('h10 + j - 1)) begin
          bad++; $display("FAIL single_addr beat=%0d got=%h exp=%h", j, bus.rom_addr, 'h10 + j - 1);
        end
      end
      if (j >= 2 && j <= 5) begin
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_last !== (j == 5) || bus.rsp_id !== '0 ||
            bus.rsp_data !== rom_mem['h10 + j - 2]) begin
          bad++;
          $display("FAIL single_rsp beat=%0d got v=%b last=%b id=%0d data=%h exp v=1 last=%b id=0 data=%h",
                   j - 1, bus.rsp_valid, bus.rsp_last, bus.rsp_id, bus.rsp_data, (j == 5), rom_mem['h10 + j - 2]);
        end
      end
      if (j == 6) begin
        total++;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_after got=%b exp=0", bus.rsp_valid); end
      end
    end
  endtask

  task automatic test_contention();
    int idx, prev;
    bit ok;
    rst_n = 1'b0;
    tick();
    set_req(0, 'h30, 0);
    set_req(1, 'h40, 0);
    tick();
    rst_n = 1'b1;
    prev = 0;
    for (int n = 0; n < 6; n++) begin
      wait_grant(idx, ok);
      total++;
      if (!ok || idx != n % 2) begin bad++; $display("FAIL contention_order n=%0d got=%0d exp=%0d", n, idx, n % 2); end
      if (n > 0) begin
        total++;
        if (int'(cyc) - prev != 2) begin bad++; $display("FAIL contention_spacing got=%0d exp=2", int'(cyc) - prev); end
      end
      prev = int'(cyc);
    end
    tick();
    bus.req = '0;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    int idx, prev;
    bit ok;
    set_req(1, 'h80, 1);
    prev = 0;
    for (int n = 0; n < 4; n++) begin
      wait_grant(idx, ok);
      total++;
      if (!ok || idx != 1) begin bad++; $display("FAIL b2b_id got=%0d exp=1", idx); end
      if (n > 0) begin
        total++;
        if (int'(cyc) - prev != 3) begin bad++; $display("FAIL b2b_spacing got=%0d exp=3", int'(cyc) - prev); end
      end
      prev = int'(cyc);
    end
    tick();
    bus.req = '0;
    repeat (5) tick();
  endtask

  task automatic test_wrap();
    int idx;
    bit ok;
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 'hFE; exp_a[1] = 'hFF; exp_a[2] = 'h00; exp_a[3] = 'h01;
    set_req(2, 'hFE, 3);
    wait_grant(idx, ok);
    total++; if (!ok || idx != 2) begin bad++; $display("FAIL wrap_gnt got=%0d exp=2", idx); end
    tick();
    bus.req = '0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      else @(negedge clk);
      total++;
      if (bus.rom_addr !== exp_a[j]) begin bad++; $display("FAIL wrap_addr beat=%0d got=%h exp=%h", j, bus.rom_addr, exp_a[j]); end
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_burst();
    int idx;
    bit ok;
    set_req(2, 'h20, 15);
    wait_grant(idx, ok);
    total++; if (!ok || idx != 2) begin bad++; $display("FAIL midrst_gnt got=%0d exp=2", idx); end
    tick();
    bus.req = '0;
    repeat (4) @(negedge clk);
    tick();
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0)      begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.rsp_id !== '0)      begin bad++; $display("FAIL midrst_id got=%0d exp=0", bus.rsp_id); end
    total++; if (bus.rsp_last !== 1'b0 || bus.rsp_err !== 1'b0) begin
      bad++; $display("FAIL midrst_flags got last=%b err=%b exp 0 0", bus.rsp_last, bus.rsp_err);
    end
    total++; if (bus.rom_addr !== '0)    begin bad++; $display("FAIL midrst_addr got=%h exp=0", bus.rom_addr); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL midrst_quiet cyc=%0d got v=%b busy=%b exp 0 0", cyc, bus.rsp_valid, bus.busy);
      end
    end
  endtask

  task automatic test_range();
    int idx;
    bit ok;
    bit exp_e;
    set_req(0, 198, 3);
    wait_grant(idx, ok);
    total++; if (!ok || idx != 0) begin bad++; $display("FAIL range_gnt got=%0d exp=0", idx); end
    tick();
    bus.req = '0;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
`ifdef ROM_ARB_RANGE_CHECK_EN
      exp_e = (b >= 2);
`else
      exp_e = 1'b0;
`endif
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== exp_e ||
          bus.rsp_data !== (exp_e ? DW'(0) : rom_mem[198 + b])) begin
        bad++;
        $display("FAIL range_beat b=%0d got v=%b err=%b data=%h exp v=1 err=%b data=%h",
                 b, bus.rsp_valid, bus.rsp_err, bus.rsp_data, exp_e, exp_e ? DW'(0) : rom_mem[198 + b]);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        bus.req[i] = ($urandom_range(0, 9) < 4);
        bus.req_addr[i*AW +: AW] = AW'($urandom);
        bus.req_len[i*LW +: LW]  = ($urandom_range(0, 7) == 0) ? LW'($urandom) : LW'($urandom_range(0, 3));
      end
    end
    tick();
    bus.req = '0;
    repeat (25) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) rom_mem[i] = DW'($urandom);
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_len = '0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_wrap();
    test_reset_mid_burst();
    test_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Round-robin arbiter and burst sequencer that shares one synchronous simulation ROM (registered read, 1-cycle latency, no enable) between N requesters.
- Each requester posts a start address and a beat count. The winner holds the ROM for the whole burst; the block auto-increments the address and returns tagged read beats.
- Sits between fetch/debug/DMA-style readers and the single ROM instance in simulation testbenches and SoC models.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 8, ROM address width
- DATA_WIDTH, 8, ROM word width
- LEN_WIDTH, 4, burst length field width; field value L means L+1 beats
- MEM_SIZE, 2**ADDR_WIDTH, populated ROM words (used only by the optional feature)
- ID_WIDTH, $clog2(N_REQ) (min 1), width of the response tag

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request; held high with addr/len stable until granted
- req_addr  in  N_REQ*ADDR_WIDTH  packed start addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_len  in  N_REQ*LEN_WIDTH  packed burst lengths minus one
- gnt  out  N_REQ  one-hot, 1-cycle acceptance pulse
- busy  out  1  high from grant cycle until the last beat is issued
- rom_addr  out  ADDR_WIDTH  address to ROM
- rom_data  in  DATA_WIDTH  ROM registered read data
- rsp_valid  out  1  read beat valid
- rsp_id  out  ID_WIDTH  index of owning requester
- rsp_last  out  1  final beat of burst
- rsp_data  out  DATA_WIDTH  beat data
- rsp_err  out  1  beat address out of range (optional feature; else 0)

Behaviour:
- Reset (async assert, sync release): state IDLE, gnt=0, busy=0, rsp_valid=0, rsp_last=0, rsp_id=0, rsp_err=0, rom_addr=0, RR pointer=0. rsp_data is don't-care while rsp_valid=0.
- Reset mid-burst aborts the burst immediately. No further beats are issued and no rsp_valid is produced after release.
- FSM IDLE:
  - If any req bit is set, pick the first set bit at or after the RR pointer, wrapping modulo N_REQ.
  - Assert gnt[winner] for that cycle only.
  - Latch req_addr, req_len and the winner id.
  - Set RR pointer = winner+1 mod N_REQ. Go to BURST.
  - If no req bit is set, stay in IDLE.
- FSM BURST:
  - Each cycle, rom_addr = current address and a beat is issued.
  - Address increments by 1, wrapping from 2^ADDR_WIDTH-1 to 0. Remaining count decrements.
  - The beat with remaining count 0 is marked last; the FSM then returns to IDLE.
- rom_addr is driven from a register. It holds its last value when not issuing.
- Response timing:
  - Beat issued in cycle t → rsp_valid, rsp_id, rsp_last (and rsp_err) registered, high in cycle t+1.
  - rsp_data = rom_data during cycle t+1.
- Latency: grant in cycle g → first beat issued g+1 → first rsp_valid g+2.
- Throughput: one beat/cycle within a burst. One IDLE (arbitration) cycle between consecutive bursts.
- No response backpressure; consumers must accept every rsp_valid beat.
- req changes after gnt are ignored until the next IDLE cycle.
- A requester whose req stays high is re-arbitrated normally. A single active requester gets back-to-back bursts separated by one cycle.
- Simultaneous requests are resolved by RR only; there is no fixed priority.

Optional Feature:
- Macro ROM_ARB_RANGE_CHECK_EN.
- Defined: a beat whose address is >= MEM_SIZE gives rsp_err=1 in its response cycle and rsp_data forced to 0. The burst still completes with all beats counted.
- Undefined: rsp_err is tied 0 and rsp_data always equals rom_data. Out-of-range addresses are passed unchanged to the ROM.

Test Plan:
- Single requester: req0, addr 0x10, len 3 → gnt0 pulse at g; rom_addr 0x10..0x13 in g+1..g+4; rsp_valid g+2..g+5 with data ROM[0x10..0x13], id 0, rsp_last only on the 4th beat.
- Contention: req0 and req1 both high from reset, each len 0 → grants alternate 0,1,0,1 with 2-cycle spacing; rsp_id sequence matches the grant order.
- Wrap-around: addr 0xFE, len 3, ADDR_WIDTH 8 → rom_addr 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-burst: len 15, rst_n low after the 5th issued beat → all outputs go to reset values immediately; no rsp_valid after release until a new grant.
- Range check (macro defined, MEM_SIZE 200): addr 198, len 3 → rsp_err 0,0,1,1; data of the last two beats = 0. With the macro undefined, rsp_err stays 0.
